mem_load_ctrl: RTL and testbench

MEM_LOAD_CTRL -- requirements
Module: mem_load_ctrl

---
 rtl/mem_load_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_load_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_load_ctrl.sv
// Load unit between the EXE/MEM stage and the data memory. It issues one word read per load,
// extracts the byte/half/word lane, and reports misalignment, timeouts and flushed loads.
module mem_load_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EXE_MEM_load_req,
  input  logic [31:0] EXE_MEM_addr,
  input  logic [2:0]  EXE_MEM_LOAD_type,
  input  logic [4:0]  EXE_MEM_rd,
  input  logic        flush,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        MEM_stall,
  output logic        MEM_load_valid,
  output logic [31:0] MEM_load_data,
  output logic [4:0]  MEM_load_rd,
  output logic        MEM_misaligned,
  output logic        MEM_bus_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        killed_q, killed_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  type_q, type_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] out_data_q, out_data_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        misal_q, misal_d;
  logic        berr_q, berr_d;

  logic accept, misal_in, valid;

  function automatic logic [31:0] extract(logic [31:0] w, logic [1:0] off, logic [2:0] ty);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (ty[1:0])
      2'b01:   r = {{24{b[7] & ~ty[2]}}, b};
      2'b10:   r = {{16{h[15] & ~ty[2]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign accept = (state_q == IDLE) && EXE_MEM_load_req && !flush;

  always_comb begin
    case (EXE_MEM_LOAD_type[1:0])
      2'b01:   misal_in = 1'b0;
      2'b10:   misal_in = EXE_MEM_addr[0];
      default: misal_in = (EXE_MEM_addr[1:0] != 2'b00);
    endcase
  end

  // Comb outputs are gated by rst so nothing leaks while the FSM is being reset.
  assign valid          = !rst && (state_q == RESP) && !flush;
  assign MEM_load_valid = valid;
  assign dmem_req       = !rst && (state_q == WAIT);
  assign MEM_stall      = !rst && ((state_q == WAIT) || (accept && !misal_in));
  assign dmem_addr      = {addr_q[31:2], 2'b00};
  assign MEM_load_data  = valid ? buf_q : out_data_q;
  assign MEM_load_rd    = valid ? rd_q  : out_rd_q;
  assign MEM_misaligned = misal_q;
  assign MEM_bus_err    = berr_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = 8'd0;
    killed_d   = 1'b0;
    addr_d     = addr_q;
    type_d     = type_q;
    rd_d       = rd_q;
    buf_d      = buf_q;
    out_data_d = out_data_q;
    out_rd_d   = out_rd_q;
    misal_d    = 1'b0;
    berr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = EXE_MEM_addr;
          type_d = EXE_MEM_LOAD_type;
          rd_d   = EXE_MEM_rd;
          if (misal_in) misal_d = 1'b1;
          else          state_d = WAIT;
        end
      end
      WAIT: begin
        killed_d = killed_q || flush;
        cnt_d    = cnt_q + 8'd1;
        if (dmem_ack) begin
          buf_d   = extract(dmem_rdata, addr_q[1:0], type_q);
          state_d = killed_d ? IDLE : RESP;
        end else if (cnt_q == CNT_LAST) begin
          // A killed load times out silently.
          berr_d  = !killed_d;
          state_d = IDLE;
        end
        if (state_d != WAIT) begin
          cnt_d    = 8'd0;
          killed_d = 1'b0;
        end
      end
      RESP: begin
        if (valid) begin
          out_data_d = buf_q;
          out_rd_d   = rd_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      killed_q   <= 1'b0;
      addr_q     <= 32'd0;
      type_q     <= 3'd0;
      rd_q       <= 5'd0;
      buf_q      <= 32'd0;
      out_data_q <= 32'd0;
      out_rd_q   <= 5'd0;
      misal_q    <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      killed_q   <= killed_d;
      addr_q     <= addr_d;
      type_q     <= type_d;
      rd_q       <= rd_d;
      buf_q      <= buf_d;
      out_data_q <= out_data_d;
      out_rd_q   <= out_rd_d;
      misal_q    <= misal_d;
      berr_q     <= berr_d;
    end
  end

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Bench for mem_load_ctrl: directed vector table, hand sequences for reset/flush,
// then random loads checked against a transaction-level model.
module tb_mem_load_ctrl;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        EXE_MEM_load_req;
  logic [31:0] EXE_MEM_addr;
  logic [2:0]  EXE_MEM_LOAD_type;
  logic [4:0]  EXE_MEM_rd;
  logic        flush;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        MEM_stall;
  logic        MEM_load_valid;
  logic [31:0] MEM_load_data;
  logic [4:0]  MEM_load_rd;
  logic        MEM_misaligned;
  logic        MEM_bus_err;

  mem_load_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .EXE_MEM_load_req(EXE_MEM_load_req), .EXE_MEM_addr(EXE_MEM_addr),
    .EXE_MEM_LOAD_type(EXE_MEM_LOAD_type), .EXE_MEM_rd(EXE_MEM_rd),
    .flush(flush), .dmem_req(dmem_req), .dmem_addr(dmem_addr),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .MEM_stall(MEM_stall),
    .MEM_load_valid(MEM_load_valid), .MEM_load_data(MEM_load_data),
    .MEM_load_rd(MEM_load_rd), .MEM_misaligned(MEM_misaligned), .MEM_bus_err(MEM_bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: last delivered result and exception pulses owed to the next cycle.
  logic [31:0] last_data;
  logic [4:0]  last_rd;
  bit          exp_misal_p, exp_berr_p;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  ty;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          ack_at;     // WAIT cycle (1-based) carrying the ack, 0 = never
    int          flush_at;   // WAIT cycle with flush, 0 = none
    bit          flush_resp; // flush during the RESP cycle
    logic [31:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit ref_misal(logic [31:0] addr, logic [2:0] ty);
    if (ty[1:0] == 2'b01) return 1'b0;
    if (ty[1:0] == 2'b10) return (addr % 2) != 0;
    return (addr % 4) != 0;
  endfunction

  function automatic logic [31:0] ref_extract(logic [31:0] rdata, logic [31:0] addr, logic [2:0] ty);
    logic [31:0] v;
    int sh;
    if (ty[1:0] == 2'b01) begin
      sh = 8 * int'(addr % 4);
      v  = (rdata >> sh) & 32'hFF;
      if (!ty[2] && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (ty[1:0] == 2'b10) begin
      sh = 16 * int'((addr / 2) % 2);
      v  = (rdata >> sh) & 32'hFFFF;
      if (!ty[2] && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  // Called just after a rising edge with the FSM idle; returns just after the edge
  // that brings it back to idle, so the next load is offered in the first idle cycle.
  task automatic do_load(input vec_t v);
    bit mis, acked, killed;
    int w;
    mis = ref_misal(v.addr, v.ty);
    EXE_MEM_load_req = 1'b1; EXE_MEM_addr = v.addr; EXE_MEM_LOAD_type = v.ty;
    EXE_MEM_rd = v.rd; flush = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    chk("acc_stall", MEM_stall, 32'(!mis));
    chk("acc_req", dmem_req, 0);
    chk("acc_valid", MEM_load_valid, 0);
    chk("acc_misal_pulse", MEM_misaligned, 32'(exp_misal_p));
    chk("acc_berr_pulse", MEM_bus_err, 32'(exp_berr_p));
    chk("acc_hold_data", MEM_load_data, last_data);
    exp_misal_p = 1'b0; exp_berr_p = 1'b0;
    @(posedge clk); #1;
    EXE_MEM_load_req = 1'b0; EXE_MEM_addr = $urandom; EXE_MEM_rd = 5'($urandom);
    if (mis) begin
      exp_misal_p = 1'b1;
      return;
    end
    acked = 1'b0; killed = 1'b0; w = 0;
    while (!acked && w < TO) begin
      w++;
      dmem_ack   = (w == v.ack_at);
      dmem_rdata = (w == v.ack_at) ? v.rdata : $urandom;
      flush      = (w == v.flush_at);
      @(negedge clk);
      chk("wait_req", dmem_req, 1);
      chk("wait_stall", MEM_stall, 1);
      chk("wait_addr", dmem_addr, v.addr & 32'hFFFF_FFFC);
      chk("wait_valid", MEM_load_valid, 0);
      if (w == v.flush_at) killed = 1'b1;
      if (w == v.ack_at)   acked  = 1'b1;
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0; flush = 1'b0;
    if (acked && !killed) begin
      flush = v.flush_resp;
      @(negedge clk);
      chk("resp_valid", MEM_load_valid, 32'(!v.flush_resp));
      chk("resp_stall", MEM_stall, 0);
      chk("resp_req", dmem_req, 0);
      if (!v.flush_resp) begin
        chk("resp_data", MEM_load_data, v.exp_data);
        chk("resp_rd", MEM_load_rd, 32'(v.rd));
      end else begin
        chk("resp_hold_data", MEM_load_data, last_data);
        chk("resp_hold_rd", MEM_load_rd, 32'(last_rd));
      end
      @(posedge clk); #1;
      flush = 1'b0;
      if (!v.flush_resp) begin
        last_data = v.exp_data;
        last_rd   = v.rd;
      end
    end else if (!killed) begin
      exp_berr_p = 1'b1;
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    chk("idle_misal", MEM_misaligned, 32'(exp_misal_p));
    chk("idle_berr", MEM_bus_err, 32'(exp_berr_p));
    chk("idle_valid", MEM_load_valid, 0);
    chk("idle_req", dmem_req, 0);
    chk("idle_stall", MEM_stall, 0);
    exp_misal_p = 1'b0; exp_berr_p = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t vecs[$];
  vec_t rv;

  initial begin
    rst = 1'b1; EXE_MEM_load_req = 1'b0; EXE_MEM_addr = '0; EXE_MEM_LOAD_type = '0;
    EXE_MEM_rd = '0; flush = 1'b0; dmem_rdata = '0; dmem_ack = 1'b0;
    last_data = '0; last_rd = '0; exp_misal_p = 1'b0; exp_berr_p = 1'b0;

    // addr, type, rd, rdata, ack_at, flush_at, flush_resp, expected data
    vecs.push_back('{32'h1003, 3'b001, 5'd1,  32'h80FF_1234, 1, 0, 1'b0, 32'hFFFF_FF80});
    vecs.push_back('{32'h2002, 3'b110, 5'd2,  32'h8001_7FFF, 5, 0, 1'b0, 32'h0000_8001});
    vecs.push_back('{32'h3001, 3'b000, 5'd3,  32'h0,         1, 0, 1'b0, 32'h0});
    vecs.push_back('{32'h4000, 3'b000, 5'd4,  32'h0,         0, 0, 1'b0, 32'h0});
    vecs.push_back('{32'h5000, 3'b010, 5'd5,  32'h1234_5678, 4, 2, 1'b0, 32'h0});
    vecs.push_back('{32'h6000, 3'b011, 5'd6,  32'hDEAD_BEEF, 1, 0, 1'b0, 32'hDEAD_BEEF});
    vecs.push_back('{32'h7001, 3'b101, 5'd7,  32'h1234_5678, 2, 0, 1'b0, 32'h0000_0056});
    vecs.push_back('{32'h7002, 3'b001, 5'd8,  32'h0081_0000, 1, 0, 1'b0, 32'hFFFF_FF81});
    vecs.push_back('{32'h8002, 3'b010, 5'd9,  32'h9ABC_0000, 3, 0, 1'b0, 32'hFFFF_9ABC});
    vecs.push_back('{32'h8000, 3'b110, 5'd10, 32'h0000_F00D, 1, 0, 1'b0, 32'h0000_F00D});
    vecs.push_back('{32'h8001, 3'b010, 5'd11, 32'h0,         1, 0, 1'b0, 32'h0});
    vecs.push_back('{32'h9000, 3'b000, 5'd12, 32'h1111_1111, 1, 0, 1'b1, 32'h1111_1111});
    vecs.push_back('{32'h9100, 3'b000, 5'd13, 32'h0,         0, 3, 1'b0, 32'h0});
    vecs.push_back('{32'h9003, 3'b101, 5'd14, 32'hAB00_0000, 2, 0, 1'b0, 32'h0000_00AB});
    vecs.push_back('{32'hA000, 3'b111, 5'd15, 32'h8000_0001, 1, 0, 1'b0, 32'h8000_0001});

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", MEM_stall, 0);
    chk("rst_valid", MEM_load_valid, 0);
    chk("rst_data", MEM_load_data, 0);
    chk("rst_rd", MEM_load_rd, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_misal", MEM_misaligned, 0);
    chk("rst_berr", MEM_bus_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) do_load(vecs[i]);
    idle_cycle();

    // A request offered together with flush is not accepted.
    EXE_MEM_load_req = 1'b1; EXE_MEM_addr = 32'hB000; EXE_MEM_LOAD_type = 3'b000; flush = 1'b1;
    @(negedge clk);
    chk("flush_idle_stall", MEM_stall, 0);
    @(posedge clk); #1;
    EXE_MEM_load_req = 1'b0; flush = 1'b0;
    idle_cycle();

    // Reset in the middle of WAIT, then a stale ack.
    EXE_MEM_load_req = 1'b1; EXE_MEM_addr = 32'hC004; EXE_MEM_LOAD_type = 3'b000; EXE_MEM_rd = 5'd20;
    @(posedge clk); #1;
    EXE_MEM_load_req = 1'b0;
    @(negedge clk);
    chk("rstw_req_before", dmem_req, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_req", dmem_req, 0);
    chk("rstw_stall", MEM_stall, 0);
    @(posedge clk); #1;
    rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
    @(negedge clk);
    chk("rstw_ack_req", dmem_req, 0);
    chk("rstw_ack_valid", MEM_load_valid, 0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    last_data = '0; last_rd = '0;
    @(negedge clk);
    chk("rstw_post_valid", MEM_load_valid, 0);
    chk("rstw_post_data", MEM_load_data, 0);
    chk("rstw_post_rd", MEM_load_rd, 0);
    chk("rstw_post_addr", dmem_addr, 0);
    chk("rstw_post_berr", MEM_bus_err, 0);
    @(posedge clk); #1;

    for (int n = 0; n < 60; n++) begin
      rv.addr       = $urandom;
      rv.ty         = 3'($urandom);
      rv.rd         = 5'($urandom);
      rv.rdata      = $urandom;
      rv.ack_at     = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      rv.flush_at   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : 0;
      rv.flush_resp = ($urandom_range(0, 7) == 0);
      rv.exp_data   = ref_extract(rv.rdata, rv.addr, rv.ty);
      do_load(rv);
    end
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
